// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-port sequencer of the unified
// instruction/data memory: FSM states, RISC-V size codes and the latched op.
package dmem_pkg;

    localparam int DMEM_ADDR_W = 14;
    localparam int WORD_W      = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RD_ISSUE  = 3'd1,
        RD_WAIT   = 3'd2,
        RD_DATA   = 3'd3,
        WR_ISSUE  = 3'd4,
        RMW_MERGE = 3'd5,
        LD_WR     = 3'd6,
        ERR       = 3'd7
    } dmem_state_e;

    typedef struct packed {
        logic                   we;
        logic [2:0]             funct3;
        logic [1:0]             byte_off;
        logic [DMEM_ADDR_W-1:0] word_addr;
        logic [WORD_W-1:0]      wdata;
    } dmem_op_t;

    // Bit offset of the addressed lane; halves use only addr[1].
    function automatic logic [4:0] lane_shift(input logic [2:0] funct3,
                                              input logic [1:0] byte_off);
        logic [4:0] sh;
        case (funct3[1:0])
            2'b00:   sh = {byte_off, 3'b000};
            2'b01:   sh = {byte_off[1], 4'b0000};
            default: sh = 5'd0;
        endcase
        return sh;
    endfunction

    // Misaligned access or a size code with no matching RISC-V instruction
    // (there are no unsigned stores, so BU/HU with we=1 are rejected).
    function automatic logic op_is_bad(input logic       we,
                                       input logic [2:0] funct3,
                                       input logic [1:0] byte_off);
        logic bad;
        case (funct3)
            F3_B:    bad = 1'b0;
            F3_H:    bad = byte_off[0];
            F3_W:    bad = (byte_off != 2'b00);
            F3_BU:   bad = we;
            F3_HU:   bad = we | byte_off[0];
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_lane_unit.sv
// Combinational lane logic: extracts and extends load data, and merges a
// byte/half store into the word read back for read-modify-write.
module dmem_lane_unit
    import dmem_pkg::*;
(
    input  logic [2:0]        funct3,
    input  logic [1:0]        byte_off,
    input  logic [WORD_W-1:0] rdata,
    input  logic [WORD_W-1:0] store_data,
    output logic [WORD_W-1:0] load_data,
    output logic [WORD_W-1:0] merged
);

    logic [4:0]        shamt_s;
    logic [WORD_W-1:0] lane_s;
    logic [WORD_W-1:0] mask_s;

    assign shamt_s = lane_shift(funct3, byte_off);
    assign lane_s  = rdata >> shamt_s;

    // Size decode drives both the load extension and the store lane mask.
    always_comb begin
        load_data = 32'h0000_0000;
        mask_s    = 32'h0000_0000;
        case (funct3)
            F3_B: begin
                load_data = {{24{lane_s[7]}}, lane_s[7:0]};
                mask_s    = 32'h0000_00FF;
            end
            F3_BU: begin
                load_data = {24'h00_0000, lane_s[7:0]};
                mask_s    = 32'h0000_00FF;
            end
            F3_H: begin
                load_data = {{16{lane_s[15]}}, lane_s[15:0]};
                mask_s    = 32'h0000_FFFF;
            end
            F3_HU: begin
                load_data = {16'h0000, lane_s[15:0]};
                mask_s    = 32'h0000_FFFF;
            end
            F3_W: begin
                load_data = lane_s;
                mask_s    = 32'hFFFF_FFFF;
            end
            default: begin
                load_data = 32'h0000_0000;
                mask_s    = 32'h0000_0000;
            end
        endcase
        merged = (rdata & ~(mask_s << shamt_s)) | ((store_data & mask_s) << shamt_s);
    end

endmodule

// File: rtl/dmem_port_ctrl.sv
// Data-port (port b) sequencer: arbitrates CPU loads/stores against the UART
// loader and runs read-modify-write for sub-word stores.
module dmem_port_ctrl
    import dmem_pkg::*;
#(
    parameter int ADDR_W       = DMEM_ADDR_W,
    parameter int DATA_W       = WORD_W,
    parameter bit LOADER_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req_valid,
    input  logic              cpu_req_we,
    input  logic [2:0]        cpu_req_funct3,
    input  logic [31:0]       cpu_req_addr,
    input  logic [DATA_W-1:0] cpu_req_wdata,
    output logic              cpu_resp_valid,
    output logic [DATA_W-1:0] cpu_resp_rdata,
    output logic              cpu_resp_err,
    output logic              cpu_stall,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    dmem_state_e       state_r;
    dmem_op_t          op_r;
    logic              resp_valid_r;
    logic              resp_err_r;
    logic              mem_we_r;
    logic              prio_ld_r;
    logic              grant_cpu_s;
    logic              grant_ld_s;
    logic              bad_s;
    logic [DATA_W-1:0] load_data_s;
    logic [DATA_W-1:0] merged_s;
    logic              unused_addr_bits_s;

    // Address bits above the memory are aliases and intentionally dropped.
    assign unused_addr_bits_s = ^cpu_req_addr[31:ADDR_W+2];

    assign bad_s = op_is_bad(cpu_req_we, cpu_req_funct3, cpu_req_addr[1:0]);

    // IDLE arbitration; on a tie the side not granted last wins.
    always_comb begin
        grant_cpu_s = 1'b0;
        grant_ld_s  = 1'b0;
        if ((state_r == IDLE) && !rst) begin
            if (cpu_req_valid && ld_valid) begin
                grant_ld_s  = prio_ld_r;
                grant_cpu_s = ~prio_ld_r;
            end else begin
                grant_cpu_s = cpu_req_valid;
                grant_ld_s  = ld_valid;
            end
        end else begin
            grant_cpu_s = 1'b0;
            grant_ld_s  = 1'b0;
        end
    end

    dmem_lane_unit u_lane (
        .funct3     (op_r.funct3),
        .byte_off   (op_r.byte_off),
        .rdata      (mem_rdata),
        .store_data (op_r.wdata),
        .load_data  (load_data_s),
        .merged     (merged_s)
    );

    // Sequencer FSM with registered response and write-enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            op_r         <= '0;
            resp_valid_r <= 1'b0;
            resp_err_r   <= 1'b0;
            mem_we_r     <= 1'b0;
            prio_ld_r    <= LOADER_FIRST;
        end else begin
            case (state_r)
                IDLE: begin
                    if (grant_cpu_s) begin
                        op_r.we        <= cpu_req_we;
                        op_r.funct3    <= cpu_req_funct3;
                        op_r.byte_off  <= cpu_req_addr[1:0];
                        op_r.word_addr <= cpu_req_addr[ADDR_W+1:2];
                        op_r.wdata     <= cpu_req_wdata;
                        prio_ld_r      <= 1'b1;
                        if (bad_s) begin
                            state_r      <= ERR;
                            resp_valid_r <= 1'b1;
                            resp_err_r   <= 1'b1;
                        end else if (cpu_req_we && (cpu_req_funct3 == F3_W)) begin
                            state_r      <= WR_ISSUE;
                            mem_we_r     <= 1'b1;
                            resp_valid_r <= 1'b1;
                        end else begin
                            state_r <= RD_ISSUE;
                        end
                    end else if (grant_ld_s) begin
                        op_r.we        <= 1'b1;
                        op_r.funct3    <= F3_W;
                        op_r.byte_off  <= 2'b00;
                        op_r.word_addr <= ld_addr;
                        op_r.wdata     <= ld_wdata;
                        prio_ld_r      <= 1'b0;
                        state_r        <= LD_WR;
                        mem_we_r       <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RD_ISSUE: state_r <= RD_WAIT;
                RD_WAIT: begin
                    resp_valid_r <= 1'b1;
                    if (op_r.we) begin
                        state_r  <= RMW_MERGE;
                        mem_we_r <= 1'b1;
                    end else begin
                        state_r <= RD_DATA;
                    end
                end
                RMW_MERGE: begin
                    // Keep the merged word so mem_wdata holds it once IDLE.
                    op_r.wdata   <= merged_s;
                    state_r      <= IDLE;
                    mem_we_r     <= 1'b0;
                    resp_valid_r <= 1'b0;
                end
                default: begin
                    state_r      <= IDLE;
                    mem_we_r     <= 1'b0;
                    resp_valid_r <= 1'b0;
                    resp_err_r   <= 1'b0;
                end
            endcase
        end
    end

    assign mem_addr       = op_r.word_addr;
    assign mem_wdata      = (state_r == RMW_MERGE) ? merged_s : op_r.wdata;
    assign mem_we         = mem_we_r & ~rst;
    assign cpu_resp_valid = resp_valid_r;
    assign cpu_resp_err   = resp_err_r;
    assign cpu_resp_rdata = (state_r == RD_DATA) ? load_data_s : 32'h0000_0000;
    assign cpu_stall      = cpu_req_valid & ~resp_valid_r;
    assign ld_ready       = grant_ld_s;
    assign busy           = (state_r != IDLE);

endmodule

// File: tb/tb_dmem_port_ctrl.sv
// Directed bench for dmem_port_ctrl with a 2-cycle-latency memory model.
module tb_dmem_port_ctrl;
    import dmem_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_req_valid = 1'b0;
    logic        cpu_req_we = 1'b0;
    logic [2:0]  cpu_req_funct3 = 3'b000;
    logic [31:0] cpu_req_addr = 32'h0;
    logic [31:0] cpu_req_wdata = 32'h0;
    logic        cpu_resp_valid;
    logic [31:0] cpu_resp_rdata;
    logic        cpu_resp_err;
    logic        cpu_stall;
    logic        ld_valid = 1'b0;
    logic        ld_ready;
    logic [13:0] ld_addr = 14'h0;
    logic [31:0] ld_wdata = 32'h0;
    logic [13:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata = 32'h0;
    logic        busy;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dmem_port_ctrl #(.ADDR_W(14), .DATA_W(32), .LOADER_FIRST(1'b1)) dut (
        .clk(clk), .rst(rst),
        .cpu_req_valid(cpu_req_valid), .cpu_req_we(cpu_req_we),
        .cpu_req_funct3(cpu_req_funct3), .cpu_req_addr(cpu_req_addr),
        .cpu_req_wdata(cpu_req_wdata), .cpu_resp_valid(cpu_resp_valid),
        .cpu_resp_rdata(cpu_resp_rdata), .cpu_resp_err(cpu_resp_err),
        .cpu_stall(cpu_stall), .ld_valid(ld_valid), .ld_ready(ld_ready),
        .ld_addr(ld_addr), .ld_wdata(ld_wdata), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    // Memory model: address sampled at end of cycle N, data valid in N+2.
    logic [31:0] mem [0:16383];
    logic [13:0] rd_addr_q = 14'h0;
    initial for (int i = 0; i < 16384; i++) mem[i] = 32'h0;
    always @(posedge clk) begin
        rd_addr_q <= mem_addr;
        mem_rdata <= mem[rd_addr_q];
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_wes;
        logic [31:0] exp_wdata;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Issue one CPU op from an IDLE cycle (+1 after an edge) and check it.
    task automatic apply_vec(input vec_t v, input string name);
        int          lat;
        int          wes;
        int          stall_bad;
        logic [31:0] rd;
        logic        er;
        logic [31:0] wdat;
        logic [13:0] wadr;
        lat = 0; wes = 0; stall_bad = 0; rd = 32'h0; er = 1'b0; wdat = 32'h0; wadr = 14'h0;
        cpu_req_valid = 1'b1; cpu_req_we = v.we; cpu_req_funct3 = v.f3;
        cpu_req_addr = v.addr; cpu_req_wdata = v.wdata;
        #1;
        if (cpu_stall !== 1'b1) stall_bad++;
        while (lat < 10) begin
            @(posedge clk); #1;
            lat++;
            if (mem_we) begin
                wes++; wdat = mem_wdata; wadr = mem_addr;
            end
            if (cpu_resp_valid) begin
                rd = cpu_resp_rdata; er = cpu_resp_err;
                if (cpu_stall !== 1'b0) stall_bad++;
                break;
            end else if (cpu_stall !== 1'b1) begin
                stall_bad++;
            end
        end
        cpu_req_valid = 1'b0; cpu_req_we = 1'b0;
        check({name, ".lat"}, lat, v.exp_lat);
        check({name, ".rdata"}, rd, v.exp_rdata);
        check({name, ".err"}, {31'h0, er}, {31'h0, v.exp_err});
        check({name, ".we_count"}, wes, v.exp_wes);
        check({name, ".stall"}, stall_bad, 0);
        if (v.exp_wes > 0) begin
            check({name, ".wdata"}, wdat, v.exp_wdata);
            check({name, ".waddr"}, {18'h0, wadr}, {18'h0, v.addr[15:2]});
        end
        @(posedge clk); #1;
    endtask

    task automatic ld_write(input logic [13:0] a, input logic [31:0] d);
        ld_valid = 1'b1; ld_addr = a; ld_wdata = d;
        #1;
        check("ld_ready", {31'h0, ld_ready}, 32'h1);
        @(posedge clk); #1;
        ld_valid = 1'b0;
        check("ld_wr.we", {31'h0, mem_we}, 32'h1);
        check("ld_wr.addr", {18'h0, mem_addr}, {18'h0, a});
        check("ld_wr.wdata", mem_wdata, d);
        @(posedge clk); #1;
    endtask

    logic [3:0]  order;
    logic [31:0] arb_rdata;
    int          nev;
    int          cyc;

    initial begin
        vecs[0]  = '{1'b0, F3_W,  32'h0000_0040, 32'h0,         32'hDEAD_BEEF, 1'b0, 3, 0, 32'h0};
        vecs[1]  = '{1'b0, F3_B,  32'h0000_0043, 32'h0,         32'hFFFF_FFDE, 1'b0, 3, 0, 32'h0};
        vecs[2]  = '{1'b0, F3_BU, 32'h0000_0043, 32'h0,         32'h0000_00DE, 1'b0, 3, 0, 32'h0};
        vecs[3]  = '{1'b0, F3_H,  32'h0000_0040, 32'h0,         32'hFFFF_BEEF, 1'b0, 3, 0, 32'h0};
        vecs[4]  = '{1'b0, F3_HU, 32'h0000_0042, 32'h0,         32'h0000_DEAD, 1'b0, 3, 0, 32'h0};
        vecs[5]  = '{1'b1, F3_B,  32'h0000_0041, 32'h0000_0012, 32'h0,         1'b0, 3, 1, 32'hDEAD_12EF};
        vecs[6]  = '{1'b0, F3_W,  32'h0000_0040, 32'h0,         32'hDEAD_12EF, 1'b0, 3, 0, 32'h0};
        vecs[7]  = '{1'b0, F3_W,  32'h0000_0042, 32'h0,         32'h0,         1'b1, 1, 0, 32'h0};
        vecs[8]  = '{1'b0, 3'b011, 32'h0000_0040, 32'h0,        32'h0,         1'b1, 1, 0, 32'h0};
        vecs[9]  = '{1'b1, F3_W,  32'h0000_0080, 32'h1122_3344, 32'h0,         1'b0, 1, 1, 32'h1122_3344};
        vecs[10] = '{1'b0, F3_W,  32'h0000_0080, 32'h0,         32'h1122_3344, 1'b0, 3, 0, 32'h0};
        vecs[11] = '{1'b1, F3_H,  32'h0000_0082, 32'hABCD_BEEF, 32'h0,         1'b0, 3, 1, 32'hBEEF_3344};
        vecs[12] = '{1'b0, F3_H,  32'h0000_0082, 32'h0,         32'hFFFF_BEEF, 1'b0, 3, 0, 32'h0};
        vecs[13] = '{1'b0, F3_H,  32'h0000_0041, 32'h0,         32'h0,         1'b1, 1, 0, 32'h0};
        vecs[14] = '{1'b0, F3_W,  32'h1000_0080, 32'h0,         32'hBEEF_3344, 1'b0, 3, 0, 32'h0};
        vecs[15] = '{1'b0, F3_BU, 32'h0000_0081, 32'h0,         32'h0000_0033, 1'b0, 3, 0, 32'h0};
        vecs[16] = '{1'b1, F3_B,  32'h0000_0083, 32'h0000_00A5, 32'h0,         1'b0, 3, 1, 32'hA5EF_3344};
        vecs[17] = '{1'b0, F3_B,  32'h0000_0083, 32'h0,         32'hFFFF_FFA5, 1'b0, 3, 0, 32'h0};

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset.outputs",
              {22'h0, cpu_resp_valid, cpu_resp_err, cpu_stall, ld_ready, mem_we, busy, 4'h0},
              32'h0);
        check("reset.rdata", cpu_resp_rdata, 32'h0);
        check("reset.mem_addr", {18'h0, mem_addr}, 32'h0);
        check("reset.mem_wdata", mem_wdata, 32'h0);

        ld_write(14'h0010, 32'hDEAD_BEEF);
        for (int i = 0; i < 18; i++) apply_vec(vecs[i], $sformatf("vec%0d", i));

        // Both requesters held from reset: expect loader, CPU, loader, CPU.
        rst = 1'b1;
        @(posedge clk); #1;
        cpu_req_valid = 1'b1; cpu_req_we = 1'b0; cpu_req_funct3 = F3_W; cpu_req_addr = 32'h40;
        ld_valid = 1'b1; ld_addr = 14'h0010; ld_wdata = 32'hCAFE_F00D;
        @(posedge clk); #1;
        rst = 1'b0;
        nev = 0; cyc = 0; order = 4'h0; arb_rdata = 32'h0;
        while (nev < 4 && cyc < 60) begin
            #1;
            if (ld_ready) begin
                order[3-nev] = 1'b1; nev++;
            end else if (cpu_resp_valid) begin
                if (nev == 1) arb_rdata = cpu_resp_rdata;
                order[3-nev] = 1'b0; nev++;
            end
            if (nev < 4) begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        check("arb.events", nev, 4);
        check("arb.order", {28'h0, order}, 32'hA);
        check("arb.first_cpu_rdata", arb_rdata, 32'hCAFE_F00D);
        cpu_req_valid = 1'b0; ld_valid = 1'b0;
        @(posedge clk); #1;

        // Reset while an SH sits in RD_WAIT: the merge write must never happen.
        cpu_req_valid = 1'b1; cpu_req_we = 1'b1; cpu_req_funct3 = F3_H;
        cpu_req_addr = 32'h40; cpu_req_wdata = 32'h0000_5555;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("abort.busy_before", {31'h0, busy}, 32'h1);
        rst = 1'b1; cpu_req_valid = 1'b0; cpu_req_we = 1'b0;
        #1;
        check("abort.we_in_rst", {31'h0, mem_we}, 32'h0);
        @(posedge clk); #1;
        check("abort.outputs",
              {26'h0, cpu_resp_valid, cpu_resp_err, cpu_stall, ld_ready, mem_we, busy},
              32'h0);
        check("abort.rdata", cpu_resp_rdata, 32'h0);
        check("abort.mem_addr", {18'h0, mem_addr}, 32'h0);
        check("abort.mem_wdata", mem_wdata, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;
        apply_vec('{1'b0, F3_W, 32'h40, 32'h0, 32'hCAFE_F00D, 1'b0, 3, 0, 32'h0}, "post_abort_lw");
        apply_vec('{1'b1, F3_W, 32'h40, 32'h0102_0304, 32'h0, 1'b0, 1, 1, 32'h0102_0304}, "post_abort_sw");
        apply_vec('{1'b0, F3_W, 32'h40, 32'h0, 32'h0102_0304, 1'b0, 3, 0, 32'h0}, "post_abort_lw2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
